rr_hold_arbiter: RTL and testbench

RR_HOLD_ARBITER -- requirements
Module: rr_hold_arbiter

---
 rtl/rr_hold_arbiter.sv | 169 ++++++++++++++++
 tb/tb_rr_hold_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_hold_arbiter.sv
// Four-requester round-robin arbiter with a bounded hold time per grant.
// A grant ends when its owner drops the request or after MAX_HOLD cycles, and one idle cycle follows.

module rr_hold_arbiter_checker #(
  parameter int CW       = 4,
  parameter int MAX_HOLD = 8
) (
  input logic          clk,
  input logic          reset,
  input logic [3:0]    gnt,
  input logic          busy,
  input logic          timeout,
  input logic [CW-1:0] hold
);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt));
  a_busy_or:    assert property (@(posedge clk) disable iff (!reset) busy == (|gnt));
  a_timeout:    assert property (@(posedge clk) disable iff (!reset) timeout |-> !busy);
  a_hold_max:   assert property (@(posedge clk) disable iff (!reset) 32'(hold) <= MAX_HOLD);

endmodule

module rr_hold_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] GNT_ID,
  output logic       BUSY,
  output logic       TIMEOUT
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX_C  = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_ONE_C  = CW'(1);
  localparam logic [CW-1:0] HOLD_ZERO_C = CW'(0);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_r,   state_s;
  logic [1:0]    ptr_r,     ptr_s;
  logic [1:0]    owner_r,   owner_s;
  logic [CW-1:0] hold_r,    hold_s;
  logic [3:0]    gnt_r,     gnt_s;
  logic          busy_r,    busy_s;
  logic          timeout_r, timeout_s;
  logic [1:0]    win_s;

  // First set request found searching upward from ptr, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        win   = win;
      end
    end
    return win;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  assign win_s = rr_pick(REQ, ptr_r);

  // Next-state and next-output decode for the IDLE/GRANT machine.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    owner_s   = owner_r;
    hold_s    = hold_r;
    gnt_s     = 4'b0000;
    busy_s    = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (REQ != 4'b0000) begin
          state_s = GRANT;
          owner_s = win_s;
          ptr_s   = win_s + 2'd1;
          hold_s  = HOLD_ONE_C;
          gnt_s   = onehot4(win_s);
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (!REQ[owner_r]) begin
          state_s = IDLE;
          hold_s  = HOLD_ZERO_C;
        end else if (hold_r >= HOLD_MAX_C) begin
          // Owner still wants the resource but has used its full allowance.
          state_s   = IDLE;
          hold_s    = HOLD_ZERO_C;
          timeout_s = 1'b1;
        end else begin
          hold_s = hold_r + HOLD_ONE_C;
          gnt_s  = onehot4(owner_r);
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        hold_s  = HOLD_ZERO_C;
      end
    endcase
  end

  // State, pointer, counter and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      ptr_r     <= 2'd0;
      owner_r   <= 2'd0;
      hold_r    <= HOLD_ZERO_C;
      gnt_r     <= 4'b0000;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      owner_r   <= owner_s;
      hold_r    <= hold_s;
      gnt_r     <= gnt_s;
      busy_r    <= busy_s;
      timeout_r <= timeout_s;
    end
  end

  assign GNT     = gnt_r;
  assign GNT_ID  = owner_r;
  assign BUSY    = busy_r;
  assign TIMEOUT = timeout_r;

  rr_hold_arbiter_checker #(
    .CW       (CW),
    .MAX_HOLD (MAX_HOLD)
  ) u_checker (
    .clk     (clk),
    .reset   (reset),
    .gnt     (gnt_r),
    .busy    (busy_r),
    .timeout (timeout_r),
    .hold    (hold_r)
  );

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed and random bench for rr_hold_arbiter, with MAX_HOLD=8 and MAX_HOLD=1 instances
// checked every cycle against a cycle-level reference model of the arbitration rules.

module tb_rr_hold_arbiter;

  localparam int MH_A = 8;
  localparam int MH_B = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] id_a, id_b;
  logic       busy_a, busy_b, to_a, to_b;

  int n_cmp = 0;
  int n_err = 0;

  int m_owner[2];
  int m_held[2];
  int m_ptr[2];
  bit m_to[2];
  int mh[2] = '{MH_A, MH_B};

  logic [3:0] prev_g[2];
  int         run_len[2];

  rr_hold_arbiter #(.MAX_HOLD(MH_A)) dut_a (
    .clk(clk), .reset(reset), .REQ(req),
    .GNT(gnt_a), .GNT_ID(id_a), .BUSY(busy_a), .TIMEOUT(to_a)
  );

  rr_hold_arbiter #(.MAX_HOLD(MH_B)) dut_b (
    .clk(clk), .reset(reset), .REQ(req),
    .GNT(gnt_b), .GNT_ID(id_b), .BUSY(busy_b), .TIMEOUT(to_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_held[k]  = 0;
      m_ptr[k]   = 0;
      m_to[k]    = 1'b0;
      prev_g[k]  = 4'b0000;
      run_len[k] = 0;
    end
  endtask

  // One clock edge of the arbitration rules, on plain integers.
  task automatic model_step(input int k, input logic [3:0] r);
    m_to[k] = 1'b0;
    if (m_owner[k] < 0) begin
      if (r != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (m_owner[k] < 0 && r[(m_ptr[k] + i) % 4]) m_owner[k] = (m_ptr[k] + i) % 4;
        end
        m_held[k] = 1;
        m_ptr[k]  = (m_owner[k] + 1) % 4;
      end
    end else if (!r[m_owner[k]]) begin
      m_owner[k] = -1;
    end else if (m_held[k] == mh[k]) begin
      m_owner[k] = -1;
      m_to[k]    = 1'b1;
    end else begin
      m_held[k]++;
    end
  endtask

  task automatic check_all();
    logic [3:0] g[2];
    logic [1:0] id[2];
    logic       b[2];
    logic       t[2];
    logic [3:0] eg;
    g[0] = gnt_a;  g[1] = gnt_b;
    id[0] = id_a;  id[1] = id_b;
    b[0] = busy_a; b[1] = busy_b;
    t[0] = to_a;   t[1] = to_b;
    for (int k = 0; k < 2; k++) begin
      eg = (m_owner[k] < 0) ? 4'b0000 : (4'b0001 << m_owner[k]);
      chk($sformatf("gnt[%0d]", k), g[k], eg);
      chk($sformatf("busy[%0d]", k), b[k], (m_owner[k] >= 0));
      chk($sformatf("timeout[%0d]", k), t[k], m_to[k]);
      if (m_owner[k] >= 0) chk($sformatf("gnt_id[%0d]", k), id[k], m_owner[k]);
      chk($sformatf("onehot0[%0d]", k), $onehot0(g[k]), 1);
      chk($sformatf("busy_or[%0d]", k), b[k], |g[k]);
      if (g[k] != 4'b0000 && prev_g[k] != 4'b0000) chk($sformatf("idle_gap[%0d]", k), g[k], prev_g[k]);
      run_len[k] = (g[k] != 4'b0000) ? run_len[k] + 1 : 0;
      chk($sformatf("hold_len[%0d]", k), (run_len[k] <= mh[k]), 1);
      prev_g[k] = g[k];
    end
  endtask

  task automatic cyc(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_step(0, r);
    model_step(1, r);
    #1;
    check_all();
  endtask

  // Short asynchronous reset pulse between clock edges; outputs must drop immediately.
  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_gnt_a", gnt_a, 4'b0000);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_to_a", to_a, 1'b0);
    chk("rst_id_a", id_a, 2'd0);
    chk("rst_gnt_b", gnt_b, 4'b0000);
    chk("rst_busy_b", busy_b, 1'b0);
    #1 reset = 1'b1;
    model_reset();
  endtask

  initial begin
    int         seq_q[$];
    int         exp_seq[5];
    int         n_to;
    int         n_hold;
    logic [3:0] prevv;
    logic [3:0] nxt;
    bit         got;
    logic [3:0] cap_g[11];
    logic       cap_t[11];
    logic [3:0] r;

    exp_seq = '{0, 1, 2, 3, 0};
    reset = 1'b0;
    req   = 4'b0000;
    model_reset();
    #3;
    chk("init_gnt", gnt_a, 4'b0000);
    chk("init_busy", busy_a, 1'b0);
    chk("init_to", to_a, 1'b0);
    chk("init_id", id_a, 2'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // All four requesting continuously: strict rotation with timeouts.
    n_to = 0;
    for (int i = 0; i < 40; i++) begin
      prevv = gnt_a;
      cyc(4'b1111);
      if (gnt_a != 4'b0000 && prevv == 4'b0000) seq_q.push_back(int'(id_a));
      if (to_a) n_to++;
    end
    chk("rot_count", seq_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < seq_q.size()) chk($sformatf("rot_seq%0d", i), seq_q[i], exp_seq[i]);
    end
    chk("rot_timeouts", n_to, 4);

    // Short request from requester 2 released by the requester.
    cyc(4'b0000);
    cyc(4'b0000);
    n_hold = 0;
    n_to   = 0;
    for (int i = 0; i < 5; i++) begin
      cyc((i < 3) ? 4'b0100 : 4'b0000);
      if (gnt_a == 4'b0100) n_hold++;
      if (to_a) n_to++;
    end
    chk("short_hold", n_hold, 3);
    chk("short_to", n_to, 0);
    chk("short_end", gnt_a, 4'b0000);

    // Owner 1 times out; the next grant searches from index 2.
    pulse_reset();
    cyc(4'b0010);
    chk("own1_gnt", gnt_a, 4'b0010);
    got = 1'b0;
    nxt = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      cyc(4'b1011);
      if (!got && gnt_a != 4'b0000 && gnt_a != 4'b0010) begin
        nxt = gnt_a;
        got = 1'b1;
      end
    end
    chk("own1_next", nxt, 4'b1000);

    // Lone requester 0: 8 grant cycles, timeout, one idle cycle, re-grant.
    pulse_reset();
    for (int i = 1; i <= 10; i++) begin
      cyc(4'b0001);
      cap_g[i] = gnt_a;
      cap_t[i] = to_a;
    end
    for (int i = 1; i <= 8; i++) chk($sformatf("lone_g%0d", i), cap_g[i], 4'b0001);
    chk("lone_gap_g", cap_g[9], 4'b0000);
    chk("lone_gap_t", cap_t[9], 1'b1);
    chk("lone_regrant", cap_g[10], 4'b0001);
    chk("lone_regrant_t", cap_t[10], 1'b0);

    // Reset in the middle of a grant, then requester 1 wins from pointer 0.
    cyc(4'b0000);
    cyc(4'b0001);
    cyc(4'b0001);
    pulse_reset();
    cyc(4'b0110);
    chk("postrst_gnt", gnt_a, 4'b0010);
    chk("postrst_id", id_a, 2'd1);

    // Random requests with long holding periods.
    r = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      cyc(r);
    end
    cyc(4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
